// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder slice.
// Optional feature macro used across the slice: MEM_BOUNDS_EN.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Index width for a store of the given depth (at least one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// memEN/RW/MFC bus between the fetch/execute initiator and the responder.
// The err line exists only when MEM_BOUNDS_EN is defined.
interface mem_responder_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              memEN;
  logic              RW;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              MFC;
`ifdef MEM_BOUNDS_EN
  logic              err;
`endif

  modport master (
    output memEN, RW, addr, data_in,
    input  data_out, MFC
`ifdef MEM_BOUNDS_EN
    , input err
`endif
  );

  modport slave (
    input  memEN, RW, addr, data_in,
    output data_out, MFC
`ifdef MEM_BOUNDS_EN
    , output err
`endif
  );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port word store: synchronous write, registered read.
// Contents have no reset; only the read register is cleared by rst.
// rclr forces the read register to zero (used for out-of-range reads
// when MEM_BOUNDS_EN is defined).
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              rclr,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Registered read port; holds its value until the next read or clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      rdata <= '0;
    else if (rclr) rdata <= '0;
    else if (re)   rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the memEN/RW/MFC four-phase handshake.
// One access per memEN assertion, committed after WAIT_CYCLES edges.
// MEM_BOUNDS_EN: enables the err output and out-of-range suppression,
// allowing non-power-of-2 DEPTH; otherwise the address wraps.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  mem_responder_if.slave  bus
);

  localparam int unsigned AW  = idx_width(DEPTH);
  localparam int unsigned WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WC_LOAD = WCW'(WAIT_CYCLES - 1);

  state_t           state, state_d;
  logic [WCW-1:0]   cnt, cnt_d;
  logic             mfc, mfc_d;
  logic             we, re, rclr;
  logic             in_range;
  logic [AW-1:0]    idx;
  logic [DATA_W-1:0] rdata;

  assign idx = bus.addr[AW-1:0];

`ifdef MEM_BOUNDS_EN
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  logic err, err_d;
  assign in_range = ({1'b0, bus.addr} < DEPTH_C);
  assign bus.err  = err;
`else
  assign in_range = 1'b1;
`endif

  // FSM, wait counter and MFC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      mfc   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      mfc   <= mfc_d;
    end
  end

`ifdef MEM_BOUNDS_EN
  // Error flag register; rises and falls together with MFC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= err_d;
  end
`endif

  // Next-state, counter and commit decode.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mfc_d   = mfc;
    we      = 1'b0;
    re      = 1'b0;
    rclr    = 1'b0;
`ifdef MEM_BOUNDS_EN
    err_d   = err;
`endif
    case (state)
      IDLE: begin
        if (bus.memEN) begin
          state_d = WAIT;
          cnt_d   = WC_LOAD;
        end
      end
      WAIT: begin
        if (!bus.memEN) begin
          state_d = IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - WCW'(1);
        end else begin
          state_d = DONE;
          mfc_d   = 1'b1;
          if (bus.RW == RW_READ) begin
            re   = in_range;
            rclr = !in_range;
          end else begin
            we   = in_range;
          end
`ifdef MEM_BOUNDS_EN
          err_d = !in_range;
`endif
        end
      end
      DONE: begin
        // A new request is only accepted after memEN has been seen low.
        if (!bus.memEN) begin
          state_d = IDLE;
          mfc_d   = 1'b0;
`ifdef MEM_BOUNDS_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.MFC      = mfc;
  assign bus.data_out = rdata;

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .rclr  (rclr),
    .addr  (idx),
    .wdata (bus.data_in),
    .rdata (rdata)
  );

endmodule
